// File: rtl/voice_if.sv
// Handshake and sample bus between a tick source / sample consumer and the voice engine.
interface voice_if #(
  parameter int NUM_VOICES = 12,
  parameter int ACC_W      = 16,
  parameter int SAMPLE_W   = 8
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic                        sample_tick;
    logic [NUM_VOICES-1:0]       key_on;
    logic [1:0]                  mode;
    logic [NUM_VOICES*ACC_W-1:0] phase_inc;
    logic [SAMPLE_W-1:0]         sample_out;
    logic                        sample_valid;
    logic                        busy;
    logic [CNT_W-1:0]            active_count;
    logic                        overrun;

    modport master (
        output sample_tick, key_on, mode, phase_inc,
        input  sample_out, sample_valid, busy, active_count, overrun
    );

    modport slave (
        input  sample_tick, key_on, mode, phase_inc,
        output sample_out, sample_valid, busy, active_count, overrun
    );
endinterface

// File: rtl/voice_engine.sv
// Time-multiplexed oscillator bank: one voice per clock, enveloped, mixed and saturated per sample tick.
module voice_engine #(
  parameter int NUM_VOICES   = 12,
  parameter int ACC_W        = 16,
  parameter int SAMPLE_W     = 8,
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 32,
  parameter int MIX_SHIFT    = 4
) (
  input logic    clk,
  input logic    reset,
  voice_if.slave bus
);
    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int CNT_W  = $clog2(NUM_VOICES + 1);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PROD_W = SAMPLE_W + ENV_W;
    localparam logic [ENV_W:0]     ATK      = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W:0]     REL      = (ENV_W+1)'(RELEASE_STEP);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [SUM_W-1:0]   OUT_MAX  = SUM_W'({SAMPLE_W{1'b1}});

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_VOICES-1:0] key_cap;
    logic [1:0]            mode_cap;
    logic [ACC_W-1:0]      phase [NUM_VOICES];
    logic [ENV_W-1:0]      env   [NUM_VOICES];
    logic [SUM_W-1:0]      sum;
    logic [CNT_W-1:0]      cnt;

    logic [ACC_W-1:0]      phase_new;
    logic [ENV_W-1:0]      env_new;
    logic [SAMPLE_W-1:0]   wave;
    logic [PROD_W-1:0]     prod;
    logic [SAMPLE_W-1:0]   contrib;

    function automatic logic [ENV_W-1:0] env_attack(input logic [ENV_W-1:0] e);
        logic [ENV_W:0] s;
        s = {1'b0, e} + ATK;
        return s[ENV_W] ? {ENV_W{1'b1}} : s[ENV_W-1:0];
    endfunction

    function automatic logic [ENV_W-1:0] env_release(input logic [ENV_W-1:0] e);
        logic [ENV_W:0] d;
        d = {1'b0, e} - REL;
        return ({1'b0, e} > REL) ? d[ENV_W-1:0] : '0;
    endfunction

    function automatic logic [SAMPLE_W-1:0] wave_of(input logic [1:0] m,
                                                   input logic [ACC_W-1:0] p);
        logic [SAMPLE_W-1:0] t;
        t = p[ACC_W-2 -: SAMPLE_W];
        case (m)
            2'd0:    return p[ACC_W-1] ? {SAMPLE_W{1'b1}} : '0;
            2'd1:    return p[ACC_W-1 -: SAMPLE_W];
            2'd2:    return p[ACC_W-1] ? ~t : t;
            default: return '0;
        endcase
    endfunction

    function automatic logic [SAMPLE_W-1:0] saturate(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] sh;
        sh = s >> MIX_SHIFT;
        return (sh > OUT_MAX) ? {SAMPLE_W{1'b1}} : sh[SAMPLE_W-1:0];
    endfunction

    // Current voice: advance phase and envelope, shape and scale its contribution.
    always_comb begin
        phase_new = phase[idx] + bus.phase_inc[idx*ACC_W +: ACC_W];
        env_new   = key_cap[idx] ? env_attack(env[idx]) : env_release(env[idx]);
        wave      = wave_of(mode_cap, phase_new);
        prod      = PROD_W'(wave) * PROD_W'(env_new);
        contrib   = prod[PROD_W-1 -: SAMPLE_W];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.sample_tick) state_nxt = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx              <= '0;
            key_cap          <= '0;
            mode_cap         <= '0;
            sum              <= '0;
            cnt              <= '0;
            bus.sample_out   <= '0;
            bus.sample_valid <= 1'b0;
            bus.active_count <= '0;
            bus.overrun      <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
                env[v]   <= '0;
            end
        end else begin
            bus.sample_valid <= 1'b0;
            // A tick outside IDLE is dropped; remember that it happened.
            if (bus.sample_tick && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.sample_tick) begin
                        key_cap  <= bus.key_on;
                        mode_cap <= bus.mode;
                        sum      <= '0;
                        cnt      <= '0;
                        idx      <= '0;
                    end
                end
                ACCUM: begin
                    phase[idx] <= phase_new;
                    env[idx]   <= env_new;
                    sum        <= sum + SUM_W'(contrib);
                    cnt        <= cnt + CNT_W'(env_new != '0);
                    idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                DONE: begin
                    bus.sample_out   <= saturate(sum);
                    bus.active_count <= cnt;
                    bus.sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_voice_engine.sv
// Directed bench for voice_engine with four voices; a second instance with no mix shift checks saturation.
module tb_voice_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    voice_if #(.NUM_VOICES(4), .ACC_W(16), .SAMPLE_W(8)) bus ();
    voice_if #(.NUM_VOICES(4), .ACC_W(16), .SAMPLE_W(8)) bus0 ();

    assign bus0.sample_tick = bus.sample_tick;
    assign bus0.key_on      = bus.key_on;
    assign bus0.mode        = bus.mode;
    assign bus0.phase_inc   = bus.phase_inc;

    voice_engine #(.NUM_VOICES(4), .ACC_W(16), .SAMPLE_W(8), .ENV_W(8),
                   .ATTACK_STEP(64), .RELEASE_STEP(32), .MIX_SHIFT(2))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));

    voice_engine #(.NUM_VOICES(4), .ACC_W(16), .SAMPLE_W(8), .ENV_W(8),
                   .ATTACK_STEP(64), .RELEASE_STEP(32), .MIX_SHIFT(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
    endtask

    // Returns the number of clocks after the tick edge at which sample_valid is seen, or -1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_sample(output int lat);
        pulse_tick();
        wait_valid(lat);
    endtask

    task automatic test_reset();
        bus.key_on = '0; bus.mode = 2'd0; bus.phase_inc = '0; bus.sample_tick = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        total++; if (bus.sample_out !== 8'd0) begin bad++; $display("FAIL reset_out got %0d want 0", bus.sample_out); end
        total++; if (bus.sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", bus.sample_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        total++; if (bus.active_count !== 3'd0) begin bad++; $display("FAIL reset_active got %0d want 0", bus.active_count); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %0b want 0", bus.overrun); end
    endtask

    task automatic test_saw();
        int lat;
        do_reset();
        bus.key_on = 4'b0001; bus.mode = 2'd1; bus.phase_inc = {16'h0, 16'h0, 16'h0, 16'h1000};
        pulse_tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL saw_busy got %0b want 1", bus.busy); end
        wait_valid(lat);
        total++; if (lat != 5) begin bad++; $display("FAIL saw_latency got %0d want 5", lat); end
        total++; if (bus.sample_out !== 8'd1) begin bad++; $display("FAIL saw_out got %0d want 1", bus.sample_out); end
        total++; if (bus.active_count !== 3'd1) begin bad++; $display("FAIL saw_active got %0d want 1", bus.active_count); end
        @(negedge clk);
        total++; if (bus.sample_valid !== 1'b0) begin bad++; $display("FAIL saw_valid_width got %0b want 0", bus.sample_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL saw_idle_busy got %0b want 0", bus.busy); end
        total++; if (bus.sample_out !== 8'd1) begin bad++; $display("FAIL saw_hold got %0d want 1", bus.sample_out); end
    endtask

    // Key/mode changes right after the tick must not affect the sample: phase 0x2000, env 128 -> 32*128>>8=16, >>2=4.
    task automatic test_capture();
        int lat;
        pulse_tick();
        bus.key_on = 4'b0000; bus.mode = 2'd3;
        wait_valid(lat);
        total++; if (lat != 5) begin bad++; $display("FAIL capture_latency got %0d want 5", lat); end
        total++; if (bus.sample_out !== 8'd4) begin bad++; $display("FAIL capture_out got %0d want 4", bus.sample_out); end
        total++; if (bus.active_count !== 3'd1) begin bad++; $display("FAIL capture_active got %0d want 1", bus.active_count); end
    endtask

    task automatic test_envelope();
        int lat;
        logic [7:0] up   [5] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd255};
        logic [7:0] down [8] = '{8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31, 8'd0};
        do_reset();
        bus.key_on = 4'b0001; bus.mode = 2'd1; bus.phase_inc = {16'h0, 16'h0, 16'h0, 16'h1000};
        for (int i = 0; i < 5; i++) begin
            run_sample(lat);
            total++; if (dut.env[0] !== up[i]) begin bad++; $display("FAIL env_attack[%0d] got %0d want %0d", i, dut.env[0], up[i]); end
        end
        bus.key_on = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            run_sample(lat);
            total++; if (dut.env[0] !== down[i]) begin bad++; $display("FAIL env_release[%0d] got %0d want %0d", i, dut.env[0], down[i]); end
            total++;
            if (bus.active_count !== ((i == 7) ? 3'd0 : 3'd1)) begin
                bad++; $display("FAIL env_active[%0d] got %0d want %0d", i, bus.active_count, (i == 7) ? 0 : 1);
            end
        end
    endtask

    task automatic test_square_sat();
        int lat;
        do_reset();
        bus.key_on = 4'b1111; bus.mode = 2'd0; bus.phase_inc = {4{16'h8000}};
        for (int i = 0; i < 4; i++) run_sample(lat);
        total++; if (bus.sample_out !== 8'd0) begin bad++; $display("FAIL square_even got %0d want 0", bus.sample_out); end
        run_sample(lat);
        total++; if (lat != 5) begin bad++; $display("FAIL square_latency got %0d want 5", lat); end
        total++; if (bus.sample_out !== 8'd254) begin bad++; $display("FAIL square_out got %0d want 254", bus.sample_out); end
        total++; if (bus0.sample_out !== 8'd255) begin bad++; $display("FAIL square_sat got %0d want 255", bus0.sample_out); end
        total++; if (bus.active_count !== 3'd4) begin bad++; $display("FAIL square_active got %0d want 4", bus.active_count); end
    endtask

    task automatic test_overrun();
        int nvalid = 0;
        do_reset();
        bus.key_on = 4'b0001; bus.mode = 2'd1; bus.phase_inc = {16'h0, 16'h0, 16'h0, 16'h1000};
        pulse_tick();
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_early got %0b want 0", bus.overrun); end
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.sample_valid) nvalid++;
        end
        total++; if (nvalid != 1) begin bad++; $display("FAIL overrun_valids got %0d want 1", nvalid); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got %0b want 1", bus.overrun); end
        total++; if (dut.phase[0] !== 16'h1000) begin bad++; $display("FAIL overrun_phase got %0h want 1000", dut.phase[0]); end
        total++; if (bus.sample_out !== 8'd1) begin bad++; $display("FAIL overrun_out got %0d want 1", bus.sample_out); end
        repeat (5) @(negedge clk);
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got %0b want 1", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        int lat;
        do_reset();
        bus.key_on = 4'b0001; bus.mode = 2'd1; bus.phase_inc = {16'h0, 16'h0, 16'h0, 16'h1000};
        pulse_tick();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got %0b want 0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.sample_valid) nvalid++;
        end
        total++; if (nvalid != 0) begin bad++; $display("FAIL midreset_valids got %0d want 0", nvalid); end
        total++; if (dut.phase[0] !== 16'h0) begin bad++; $display("FAIL midreset_phase got %0h want 0", dut.phase[0]); end
        total++; if (dut.env[0] !== 8'h0) begin bad++; $display("FAIL midreset_env got %0d want 0", dut.env[0]); end
        run_sample(lat);
        total++; if (lat != 5) begin bad++; $display("FAIL midreset_latency got %0d want 5", lat); end
        total++; if (bus.sample_out !== 8'd1) begin bad++; $display("FAIL midreset_out got %0d want 1", bus.sample_out); end
        total++; if (bus.active_count !== 3'd1) begin bad++; $display("FAIL midreset_active got %0d want 1", bus.active_count); end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_capture();
        test_envelope();
        test_square_sat();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
